bcd_counter: RTL and testbench

BCD_COUNTER -- requirements
Module: bcd_counter

---
 rtl/bcd_counter_pkg.sv | 19 +
 rtl/bcd_counter_digit_step.sv | 20 ++
 rtl/bcd_counter.sv | 97 +++++++++
 tb/tb_bcd_counter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_pkg.sv
// bcd_counter_pkg: shared BCD widths and decimal-to-BCD constant encoding.
package bcd_counter_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int MAX_DIGITS  = 4;

    function automatic logic [MAX_DIGITS*BCD_DIGIT_W-1:0] dec_to_bcd(input int unsigned value);
        int unsigned v;
        logic [MAX_DIGITS*BCD_DIGIT_W-1:0] r;
        v = value;
        r = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_DIGIT_W'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter_digit_step.sv
// bcd_digit_step: one BCD digit +/-1 with ripple carry (up) or borrow (down).
module bcd_digit_step
    import bcd_counter_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    input  logic                   dir_i,
    input  logic                   cin_i,
    output logic [BCD_DIGIT_W-1:0] digit_o,
    output logic                   cout_o
);

    logic edge_digit;

    assign edge_digit = dir_i ? (digit_i == 4'd0) : (digit_i == 4'd9);
    assign cout_o     = cin_i & edge_digit;
    assign digit_o    = !cin_i     ? digit_i :
                        edge_digit ? (dir_i ? 4'd9 : 4'd0) :
                        dir_i      ? digit_i - 4'd1 : digit_i + 4'd1;

endmodule

// File: rtl/bcd_counter.sv
// bcd_counter: bounded up/down BCD counter with clear, checked load and wrap/saturate.
module bcd_counter
    import bcd_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int MAX_VALUE  = 59,
    parameter int MIN_VALUE  = 0,
    parameter int WRAP       = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              en_i,
    input  logic                              dir_i,
    input  logic                              clear_i,
    input  logic                              load_i,
    input  logic [NUM_DIGITS*BCD_DIGIT_W-1:0] load_value_i,
    output logic [NUM_DIGITS*BCD_DIGIT_W-1:0] value_o,
    output logic                              carry_o,
    output logic                              at_max_o,
    output logic                              at_min_o,
    output logic                              load_err_o
);

    localparam int W = NUM_DIGITS * BCD_DIGIT_W;
    localparam logic [MAX_DIGITS*BCD_DIGIT_W-1:0] MIN_FULL = dec_to_bcd(MIN_VALUE);
    localparam logic [MAX_DIGITS*BCD_DIGIT_W-1:0] MAX_FULL = dec_to_bcd(MAX_VALUE);
    localparam logic [W-1:0] MIN_BCD = MIN_FULL[W-1:0];
    localparam logic [W-1:0] MAX_BCD = MAX_FULL[W-1:0];
    localparam bit WRAP_EN = (WRAP != 0);

    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("bcd_counter: NUM_DIGITS must be 1..4");
    end
    if (MAX_VALUE >= 10**NUM_DIGITS) begin : g_bad_max
        $error("bcd_counter: MAX_VALUE does not fit in NUM_DIGITS");
    end
    if (MIN_VALUE < 0 || MIN_VALUE >= MAX_VALUE) begin : g_bad_min
        $error("bcd_counter: MIN_VALUE must be below MAX_VALUE");
    end

    logic [W-1:0]        value_q, value_d, step_value;
    logic                load_err_q, load_err_d;
    logic [NUM_DIGITS:0] carry;
    logic                carry_unused;
    logic                load_ok;

    assign carry[0]     = 1'b1;
    assign carry_unused = carry[NUM_DIGITS];

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        bcd_digit_step u_step (
            .digit_i (value_q[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dir_i   (dir_i),
            .cin_i   (carry[d]),
            .digit_o (step_value[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cout_o  (carry[d+1])
        );
    end

    // With every nibble <= 9, BCD ordering matches decimal ordering.
    always_comb begin
        load_ok = (load_value_i >= MIN_BCD) && (load_value_i <= MAX_BCD);
        for (int i = 0; i < NUM_DIGITS; i++)
            if (load_value_i[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) load_ok = 1'b0;
    end

    assign at_max_o   = (value_q == MAX_BCD);
    assign at_min_o   = (value_q == MIN_BCD);
    assign carry_o    = en_i & ~clear_i & ~load_i & WRAP_EN & (dir_i ? at_min_o : at_max_o);
    assign value_o    = value_q;
    assign load_err_o = load_err_q;

    always_comb begin
        value_d    = value_q;
        load_err_d = 1'b0;
        if (clear_i) begin
            value_d = MIN_BCD;
        end else if (load_i) begin
            value_d    = load_ok ? load_value_i : value_q;
            load_err_d = !load_ok;
        end else if (en_i) begin
            value_d = carry_o                      ? (dir_i ? MAX_BCD : MIN_BCD) :
                      (dir_i ? at_min_o : at_max_o) ? value_q : step_value;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q    <= MIN_BCD;
            load_err_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            load_err_q <= load_err_d;
        end
    end

endmodule

// File: tb/tb_bcd_counter.sv
// tb_bcd_counter: directed and random checks of two counter configurations against an integer model.
module tb_bcd_counter;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       en = 1'b0, dir = 1'b0, clear = 1'b0, load = 1'b0;
    logic [7:0] lv = 8'h00;
    logic [7:0] val_a, val_b;
    logic       car_a, car_b, mx_a, mx_b, mn_a, mn_b, er_a, er_b;
    int         n_chk = 0, n_fail = 0;
    int         mv[2];
    bit         me[2];

    always #5 clk = ~clk;

    bcd_counter u_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .dir_i(dir), .clear_i(clear),
        .load_i(load), .load_value_i(lv), .value_o(val_a), .carry_o(car_a),
        .at_max_o(mx_a), .at_min_o(mn_a), .load_err_o(er_a)
    );

    bcd_counter #(.NUM_DIGITS(2), .MAX_VALUE(23), .MIN_VALUE(1), .WRAP(0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .dir_i(dir), .clear_i(clear),
        .load_i(load), .load_value_i(lv), .value_o(val_b), .carry_o(car_b),
        .at_max_o(mx_b), .at_min_o(mn_b), .load_err_o(er_b)
    );

    function automatic int minv(int k); return k ? 1 : 0; endfunction
    function automatic int maxv(int k); return k ? 23 : 59; endfunction
    function automatic bit wrp(int k); return k == 0; endfunction

    function automatic logic [7:0] enc(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic bit load_ok(int k);
        int v = int'(lv[7:4]) * 10 + int'(lv[3:0]);
        return lv[7:4] <= 9 && lv[3:0] <= 9 && v >= minv(k) && v <= maxv(k);
    endfunction

    function automatic int model_next(int k);
        int v = mv[k];
        if (clear) return minv(k);
        if (load) return load_ok(k) ? int'(lv[7:4]) * 10 + int'(lv[3:0]) : v;
        if (!en) return v;
        if (dir) return v == minv(k) ? (wrp(k) ? maxv(k) : v) : v - 1;
        return v == maxv(k) ? (wrp(k) ? minv(k) : v) : v + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mv[k] <= minv(k);
                me[k] <= 1'b0;
            end else begin
                mv[k] <= model_next(k);
                me[k] <= !clear && load && !load_ok(k);
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(int k, logic [7:0] v, logic c, logic mx, logic mn, logic e);
        string p = k ? "b" : "a";
        chk({p, ".value"}, v, enc(mv[k]));
        chk({p, ".carry"}, c, en && !clear && !load && wrp(k) &&
                              (dir ? mv[k] == minv(k) : mv[k] == maxv(k)));
        chk({p, ".at_max"}, mx, mv[k] == maxv(k));
        chk({p, ".at_min"}, mn, mv[k] == minv(k));
        chk({p, ".load_err"}, e, me[k]);
    endtask

    always @(negedge clk) begin
        cmp(0, val_a, car_a, mx_a, mn_a, er_a);
        cmp(1, val_b, car_b, mx_b, mn_b, er_b);
    end

    task automatic do_load(logic [7:0] v);
        @(posedge clk); #1;
        load = 1'b1;
        lv   = v;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_value", val_a, 8'h00);
        chk("rst_b_value", val_b, 8'h01);
        chk("rst_a_err", er_a, 1'b0);
        rst_n = 1'b1;
        en    = 1'b1;
        dir   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("up_value", val_a, enc(i));
            chk("up_carry", car_a, i == 59);
        end
        @(negedge clk);
        chk("wrap_value", val_a, 8'h00);
        @(posedge clk); #1;
        en   = 1'b0;
        load = 1'b1;
        lv   = 8'h00;
        @(posedge clk); #1;
        load = 1'b0;
        en   = 1'b1;
        dir  = 1'b1;
        @(negedge clk);
        chk("down_start", val_a, 8'h00);
        chk("down_carry", car_a, 1'b1);
        @(negedge clk);
        chk("down_59", val_a, 8'h59);
        chk("down_59_carry", car_a, 1'b0);
        @(negedge clk);
        chk("down_58", val_a, 8'h58);
        @(negedge clk);
        chk("down_57", val_a, 8'h57);
        @(posedge clk); #1;
        en = 1'b0;
        do_load(8'h30);
        @(negedge clk);
        chk("load_30", val_a, 8'h30);
        chk("load_30_err", er_a, 1'b0);
        do_load(8'h5A);
        @(negedge clk);
        chk("load_5a_err", er_a, 1'b1);
        chk("load_5a_value", val_a, 8'h30);
        @(negedge clk);
        chk("load_5a_err_end", er_a, 1'b0);
        do_load(8'h60);
        @(negedge clk);
        chk("load_60_err", er_a, 1'b1);
        chk("load_60_value", val_a, 8'h30);
        @(negedge clk);
        chk("load_60_err_end", er_a, 1'b0);
        do_load(8'h42);
        @(negedge clk);
        chk("load_42", val_a, 8'h42);
        chk("load_42_err", er_a, 1'b0);
        do_load(8'h23);
        en  = 1'b1;
        dir = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("sat_value", val_b, 8'h23);
            chk("sat_carry", car_b, 1'b0);
        end
        @(posedge clk); #1;
        clear = 1'b1;
        load  = 1'b1;
        lv    = 8'h05;
        @(negedge clk);
        chk("prio_carry", car_b, 1'b0);
        @(posedge clk); #1;
        clear = 1'b0;
        load  = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        chk("prio_value", val_b, 8'h01);
        do_load(8'h09);
        en = 1'b1;
        @(negedge clk);
        chk("ripple_09", val_b, 8'h09);
        @(negedge clk);
        chk("ripple_10", val_b, 8'h10);
        @(posedge clk); #1;
        en = 1'b0;
        do_load(8'h36);
        en = 1'b1;
        @(negedge clk);
        chk("run_36", val_a, 8'h36);
        @(posedge clk); #1;
        chk("run_37", val_a, 8'h37);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_value", val_a, 8'h00);
        chk("async_rst_err", er_a, 1'b0);
        chk("async_rst_b", val_b, 8'h01);
        @(posedge clk); #1;
        rst_n = 1'b1;
        en    = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst_n = $urandom_range(0, 299) != 0;
            clear = $urandom_range(0, 15) == 0;
            load  = $urandom_range(0, 7) == 0;
            lv    = $urandom_range(0, 1) ? 8'($urandom) : enc($urandom_range(0, 60));
            en    = $urandom_range(0, 3) != 0;
            dir   = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        {en, clear, load} = 3'b000;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
